// File: rtl/alarm_zone_ctrl.sv
// alarm_zone_ctrl: N-zone alarm with per-zone sync/debounce, exit/entry delays and latched siren
module alarm_zone_ctrl #(
  parameter int N_ZONES = 3,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE = 4,
  parameter int EXIT_DELAY = 16,
  parameter int ENTRY_DELAY = 16,
  localparam int MAX_DELAY = (EXIT_DELAY > ENTRY_DELAY) ? EXIT_DELAY : ENTRY_DELAY,
  localparam int CW = $clog2(MAX_DELAY + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_ZONES-1:0] sensor_in,
  input  logic [N_ZONES-1:0] zone_en,
  input  logic [N_ZONES-1:0] instant_en,
  input  logic               arm,
  input  logic               disarm,
  output logic               alarm,
  output logic               armed,
  output logic               pre_alarm,
  output logic [2:0]         state,
  output logic [N_ZONES-1:0] tripped,
  output logic [CW-1:0]      countdown
);
  localparam int DW = $clog2(DEBOUNCE + 1);
  typedef enum logic [2:0] {
    DISARMED = 3'd0, EXIT = 3'd1, ARMED = 3'd2, ENTRY = 3'd3, ALARM = 3'd4
  } state_t;
  state_t st, st_nxt;
  logic [CW-1:0] cd, cd_nxt;
  logic [N_ZONES-1:0] qual, hit, inst, trip_nxt;
  for (genvar i = 0; i < N_ZONES; i++) begin : g_zone
    logic [SYNC_STAGES-1:0] sync;
    logic [DW-1:0] cnt;
    logic q;
    // qual rises on the edge the counter saturates and holds while samples stay high
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        sync <= '0;
        cnt <= '0;
        q <= 1'b0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], sensor_in[i]};
        if (!sync[SYNC_STAGES-1]) begin
          cnt <= '0;
          q <= 1'b0;
        end else if (cnt != DW'(DEBOUNCE)) begin
          cnt <= cnt + 1'b1;
          q <= (cnt == DW'(DEBOUNCE - 1));
        end
      end
    assign qual[i] = q;
  end
  assign hit = qual & zone_en;
  assign inst = hit & instant_en;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= DISARMED;
      cd <= '0;
      tripped <= '0;
    end else begin
      st <= st_nxt;
      cd <= cd_nxt;
      tripped <= trip_nxt;
    end
  always_comb begin
    st_nxt = st;
    cd_nxt = cd;
    trip_nxt = (st == ARMED || st == ENTRY || st == ALARM) ? (tripped | hit) : tripped;
    if (disarm && st != DISARMED) begin
      st_nxt = DISARMED;
      cd_nxt = '0;
    end else
      case (st)
        DISARMED:
          if (arm) begin
            st_nxt = EXIT;
            cd_nxt = CW'(EXIT_DELAY);
            trip_nxt = '0;
          end
        EXIT: begin
          if (cd == CW'(1)) st_nxt = ARMED;
          cd_nxt = cd - 1'b1;
        end
        ARMED:
          if (|inst) st_nxt = ALARM;
          else if (|hit) begin
            st_nxt = ENTRY;
            cd_nxt = CW'(ENTRY_DELAY);
          end
        ENTRY:
          if (|inst || cd == CW'(1)) begin
            st_nxt = ALARM;
            cd_nxt = '0;
          end else cd_nxt = cd - 1'b1;
        ALARM: ;
        default: begin
          st_nxt = DISARMED;
          cd_nxt = '0;
        end
      endcase
  end
  assign state = st;
  assign countdown = cd;
  assign alarm = (st == ALARM);
  assign armed = (st == ARMED || st == ENTRY);
  assign pre_alarm = (st == ENTRY);
endmodule

// File: doc/alarm_zone_ctrl.md
Name: alarm_zone_ctrl

Overview:
Parametrised successor to the three-input combinational motion/door/window alarm. It generalises to N_ZONES sensor channels, each with a synchroniser, a debouncer, an enable mask and an instant-trip mask. An arm/disarm state machine adds exit and entry delays and a latched alarm. It sits behind the top-level pin wrapper, which maps ui_in to sensors and controls and uo_out to the status outputs.

Parameters:
N_ZONES, 3, number of sensor channels (1..8)
SYNC_STAGES, 2, flip-flops in each input synchroniser (>=2)
DEBOUNCE, 4, consecutive high synchronised samples needed to qualify a zone (>=1)
EXIT_DELAY, 16, cycles spent in EXIT before ARMED (>=1)
ENTRY_DELAY, 16, cycles spent in ENTRY before ALARM (>=1)

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  asynchronous, active-high reset
sensor_in  in  N_ZONES  raw asynchronous sensor levels, 1 = tripped
zone_en  in  N_ZONES  per-zone enable; 0 = zone ignored (synchronous to clk)
instant_en  in  N_ZONES  per-zone instant mask; 1 = trip goes straight to ALARM
arm  in  1  arm request, sampled each cycle
disarm  in  1  disarm request, sampled each cycle
alarm  out  1  siren drive, high only in ALARM
armed  out  1  high in ARMED or ENTRY
pre_alarm  out  1  high only in ENTRY (warning chirp)
state  out  3  DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4
tripped  out  N_ZONES  sticky record of the zones that qualified while armed
countdown  out  CW  cycles remaining in EXIT or ENTRY; 0 elsewhere. CW = $clog2(max(EXIT_DELAY,ENTRY_DELAY)+1)

Behaviour:
- Reset (async assert, sync release): state=DISARMED. All sync flops, debounce counters, qual, tripped and countdown are 0, so every output is 0.
- Per-zone input path: SYNC_STAGES flop chain, then a debounce counter that saturates at DEBOUNCE.
  - Counter increments on each high synchronised sample.
  - A low synchronised sample clears the counter and qual[i] on the same edge.
  - qual[i] is registered. It goes high on the edge where the counter reaches DEBOUNCE.
  - A level held high from before edge 1 gives qual high after edge SYNC_STAGES+DEBOUNCE (edge 6 with defaults).
- hit = qual & zone_en; inst = hit & instant_en. The FSM reacts to hit/inst on the next edge.
- The input path runs in every state. Only the FSM use of hit is state-gated.
- FSM transitions, evaluated each edge, disarm priority first:
  - disarm=1 in any state other than DISARMED: go to DISARMED and set countdown=0. Disarm wins over a simultaneous arm or trip.
  - DISARMED: arm=1 goes to EXIT, loads countdown=EXIT_DELAY and clears tripped.
  - EXIT: hit is ignored. countdown decrements each cycle. When countdown==1 the next edge goes to ARMED with countdown=0. EXIT therefore lasts exactly EXIT_DELAY cycles.
  - ARMED: |inst goes to ALARM. Otherwise |hit goes to ENTRY and loads countdown=ENTRY_DELAY.
  - ENTRY: |inst goes to ALARM immediately. Otherwise countdown decrements, and countdown==1 goes to ALARM on the next edge.
  - ALARM: latched. Leaves only on disarm. Trips clearing or zones being disabled do not release it.
- arm in any state other than DISARMED is ignored.
- Clearing hit or zone_en during ENTRY does not cancel the countdown.
- tripped[i] is set on any edge where hit[i]=1 and state is ARMED, ENTRY or ALARM. It holds through disarm and clears only on an accepted arm or on reset.
- Outputs alarm, armed, pre_alarm and countdown are decoded from registered state and counter. They carry no combinational path from the inputs.
- rst asserted mid-countdown or mid-ALARM returns to the reset values immediately, with no wait for a clock edge.
- Encodings 5-7 are unreachable. If reached, the FSM goes to DISARMED on the next edge.

Test Plan:
- Defaults. Pulse arm 1 cycle, then hold all inputs 0 → state=1 for 16 cycles with countdown 16,15..1, then state=2 with armed=1 and countdown=0.
- ARMED, zone0 (door) enabled, instant_en=0, sensor_in=001 held → qual at edge 6, state=3 at edge 7 with countdown=16 and pre_alarm=1. With no disarm, state=4 and alarm=1 sixteen cycles later, and tripped=001.
- ARMED, zone2 (window) instant_en=1, sensor_in=100 held → state=4 at edge 7 of the trip and tripped=100. Dropping sensor_in to 000 keeps alarm=1. Pulse disarm → state=0 with alarm=0 and tripped still 100.
- Glitch rejection. In ARMED, zone1 high for 3 cycles then low → state stays 2 and tripped=000. Holding 4+ cycles (plus sync) → ENTRY.
- Priority. arm=1 and disarm=1 in the same cycle during ENTRY → DISARMED. Raise arm alone in ARMED → no change. zone_en=000 with all sensors high → stays ARMED.
- Assert rst asynchronously mid-ENTRY (countdown=9) → all outputs 0 before the next clk edge. After release, arm works normally.
